// File: rtl/frame_kernel_engine.sv
// In-place 3x3 frame kernel engine: streams the frame buffer once in raster order
// and writes each result IMG_W+1 pixels behind the read pointer.
module frame_kernel_engine #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int PIX_W  = 4,
    parameter int ADDR_W = 17
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [1:0]           mode_i,
    input  logic [PIX_W-1:0]     thresh_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [3*PIX_W-1:0]   rd_data_i,
    output logic                 wr_en_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [3*PIX_W-1:0]   wr_data_o
);
    localparam int N     = IMG_W * IMG_H;
    localparam int CNT_W = ADDR_W + 1;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int GW    = PIX_W + 4;

    localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] FIRST_WR = CNT_W'(IMG_W + 2);
    localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(N + IMG_W + 1);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(N + IMG_W + 2);
    localparam logic [XW-1:0]    X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(IMG_H - 1);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [XW-1:0]            xin_q;
    logic [XW-1:0]            ox_q;
    logic [YW-1:0]            oy_q;
    logic [ADDR_W-1:0]        wpos_q;
    logic [1:0]               mode_q;
    logic [PIX_W-1:0]         thr_q;
    logic                     accept;
    logic                     vld_p0;
    logic                     wvld_p0;

    logic [PIX_W-1:0]         lb0 [IMG_W];
    logic [PIX_W-1:0]         lb1 [IMG_W];
    logic [PIX_W-1:0]         bot_p0, bot_p1, bot_p2;
    logic [PIX_W-1:0]         mid_p0, mid_p1, mid_p2;
    logic [PIX_W-1:0]         top_p0, top_p1, top_p2;
    logic signed [GW-1:0]     gx, gy;
    logic [PIX_W-1:0]         mag;
    logic [PIX_W-1:0]         res;
    logic                     border;
    logic [2*PIX_W-1:0]       rd_rgb_unused;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    function automatic logic [GW-1:0] abs_s(input logic signed [GW-1:0] v);
        return v[GW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [PIX_W-1:0] sat_pix(input logic [GW-1:0] v);
        return (v > GW'(PIX_MAX)) ? PIX_MAX : v[PIX_W-1:0];
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i && !abort_i) state_d = READ;
            READ: begin
                if (abort_i)                state_d = IDLE;
                else if (cnt_q == LAST_RD)  state_d = FLUSH;
            end
            FLUSH: begin
                if (abort_i)                state_d = IDLE;
                else if (cnt_q == END_CNT)  state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en_o   = (state_q == READ);
        rd_addr_o = (state_q == READ) ? cnt_q[ADDR_W-1:0] : '0;
        busy_o    = (state_q == READ) || (state_q == FLUSH);
        done_o    = (state_q == DONE);
    end

    // cnt_q = cycles since accept; pixel q sits on rd_data_i when cnt_q = q+1
    assign accept  = ((state_q == IDLE) || (state_q == DONE)) && start_i && !abort_i;
    assign vld_p0  = busy_o && (cnt_q != '0);
    assign wvld_p0 = busy_o && !abort_i && (cnt_q >= FIRST_WR) && (cnt_q <= LAST_WR);
    assign rd_rgb_unused = rd_data_i[3*PIX_W-1:PIX_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            xin_q  <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            wpos_q <= '0;
            mode_q <= '0;
            thr_q  <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            xin_q  <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            wpos_q <= '0;
            mode_q <= mode_i;
            thr_q  <= thresh_i;
        end else if (busy_o) begin
            cnt_q <= cnt_q + 1'b1;
            if (vld_p0) xin_q <= (xin_q == X_LAST) ? '0 : xin_q + 1'b1;
            if (wvld_p0) begin
                wpos_q <= wpos_q + 1'b1;
                if (ox_q == X_LAST) begin
                    ox_q <= '0;
                    oy_q <= oy_q + 1'b1;
                end else begin
                    ox_q <= ox_q + 1'b1;
                end
            end
        end
    end

    // ---- stage p0: incoming pixel plus the same column one and two lines up
    assign bot_p0 = rd_data_i[PIX_W-1:0];
    assign mid_p0 = lb0[xin_q];
    assign top_p0 = lb1[xin_q];

    // ---- stage p1/p2: horizontal shift of all three window rows
    always_ff @(posedge clk_i) begin
        if (vld_p0) begin
            lb0[xin_q] <= bot_p0;
            lb1[xin_q] <= mid_p0;
            bot_p1     <= bot_p0;
            bot_p2     <= bot_p1;
            mid_p1     <= mid_p0;
            mid_p2     <= mid_p1;
            top_p1     <= top_p0;
            top_p2     <= top_p1;
        end
    end

    // Window centre is mid_p1; column p0 is right, p2 is left
    always_comb begin
        gx = (ext(top_p0) + (ext(mid_p0) <<< 1) + ext(bot_p0))
           - (ext(top_p2) + (ext(mid_p2) <<< 1) + ext(bot_p2));
        gy = (ext(bot_p2) + (ext(bot_p1) <<< 1) + ext(bot_p0))
           - (ext(top_p2) + (ext(top_p1) <<< 1) + ext(top_p0));
        mag    = sat_pix(abs_s(gx) + abs_s(gy));
        border = (ox_q == '0) || (ox_q == X_LAST) || (oy_q == '0) || (oy_q == Y_LAST);
        case (mode_q)
            2'b00:   res = mid_p1;
            2'b01:   res = border ? '0 : mag;
            2'b10:   res = (border || (mag < thr_q)) ? '0 : PIX_MAX;
            default: res = PIX_MAX - mid_p1;
        endcase
    end

    // ---- write port: registered, zero whenever no write is issued
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else if (wvld_p0) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= wpos_q;
            wr_data_o <= {3{res}};
        end else begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end
    end
endmodule
